// File: rtl/seq_alu_pkg.sv
// ============================================================================
// seq_alu_pkg : op codes, funct3 codes and FSM state type for seq_alu
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Base op codes are {funct7[5], funct3}
   localparam logic [3:0] C_OP_ADD  = 4'b0000;
   localparam logic [3:0] C_OP_SUB  = 4'b1000;
   localparam logic [3:0] C_OP_AND  = 4'b0111;
   localparam logic [3:0] C_OP_OR   = 4'b0110;
   localparam logic [3:0] C_OP_XOR  = 4'b0100;
   localparam logic [3:0] C_OP_SLL  = 4'b0001;
   localparam logic [3:0] C_OP_SRL  = 4'b0101;
   localparam logic [3:0] C_OP_SRA  = 4'b1101;
   localparam logic [3:0] C_OP_SLT  = 4'b0010;
   localparam logic [3:0] C_OP_SLTU = 4'b0011;

   localparam logic [2:0] C_F3_MUL    = 3'b000;
   localparam logic [2:0] C_F3_MULH   = 3'b001;
   localparam logic [2:0] C_F3_MULHSU = 3'b010;
   localparam logic [2:0] C_F3_MULHU  = 3'b011;
   localparam logic [2:0] C_F3_DIV    = 3'b100;
   localparam logic [2:0] C_F3_DIVU   = 3'b101;
   localparam logic [2:0] C_F3_REM    = 3'b110;
   localparam logic [2:0] C_F3_REMU   = 3'b111;

endpackage

`default_nettype wire

// File: rtl/seq_alu_if.sv
// ============================================================================
// seq_alu_if : request/response handshake bundle for seq_alu
// Rev 1.0
// ============================================================================
`default_nettype none

interface seq_alu_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      op;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            sign;
   logic            overflow;
   logic            carry;
   logic            illegal;

   modport master (
      output in_valid, op, op1, op2, out_ready,
      input  in_ready, out_valid, result, zero, sign, overflow, carry, illegal
   );

   modport slave (
      input  in_valid, op, op1, op2, out_ready,
      output in_ready, out_valid, result, zero, sign, overflow, carry, illegal
   );
endinterface

`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
// ============================================================================
// seq_alu_muldiv : radix-2 shift-add multiplier / restoring divider on magnitudes
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_alu_muldiv
   import seq_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_start,
   input  logic [2:0]      i_f3,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);
   localparam int CW = $clog2(XLEN);

   logic            r_busy, r_is_div, r_neg_q, r_neg_r;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_f3;
   logic [XLEN-1:0] r_hi, r_lo, r_b;

   logic            w_a_sgn, w_b_sgn, w_neg_a, w_neg_b, w_ge;
   logic [XLEN:0]   w_sum, w_sh, w_diff;
   logic [XLEN-1:0] w_nhi, w_nlo, w_quo, w_rem;
   logic [2*XLEN-1:0] w_prod, w_prod_s;

   assign w_a_sgn = (i_f3 == C_F3_MULH) || (i_f3 == C_F3_MULHSU) ||
                    (i_f3 == C_F3_DIV)  || (i_f3 == C_F3_REM);
   assign w_b_sgn = (i_f3 == C_F3_MULH) || (i_f3 == C_F3_DIV) || (i_f3 == C_F3_REM);
   assign w_neg_a = w_a_sgn & i_a[XLEN-1];
   assign w_neg_b = w_b_sgn & i_b[XLEN-1];

   // One step of either algorithm; the final step feeds o_result directly
   assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
   assign w_sh   = {r_hi, r_lo[XLEN-1]};
   assign w_diff = w_sh - {1'b0, r_b};
   assign w_ge   = ~w_diff[XLEN];
   assign w_nhi  = r_is_div ? (w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0]) : w_sum[XLEN:1];
   assign w_nlo  = r_is_div ? {r_lo[XLEN-2:0], w_ge} : {w_sum[0], r_lo[XLEN-1:1]};

   assign w_prod   = {w_nhi, w_nlo};
   assign w_prod_s = r_neg_q ? -w_prod : w_prod;
   assign w_quo    = r_neg_q ? -w_nlo : w_nlo;
   assign w_rem    = r_neg_r ? -w_nhi : w_nhi;
   assign o_done   = r_busy && (r_cnt == CW'(XLEN-1));

   always_comb begin
      o_result = '0;
      case (r_f3)
         C_F3_MUL:                         o_result = w_prod_s[XLEN-1:0];
         C_F3_MULH, C_F3_MULHSU, C_F3_MULHU: o_result = w_prod_s[2*XLEN-1:XLEN];
         C_F3_DIV, C_F3_DIVU:              o_result = w_quo;
         default:                          o_result = w_rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_cnt    <= '0;
         r_f3     <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_b      <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_is_div <= i_f3[2];
         r_neg_q  <= w_neg_a ^ w_neg_b;
         r_neg_r  <= w_neg_a;
         r_cnt    <= '0;
         r_f3     <= i_f3;
         r_hi     <= '0;
         r_lo     <= w_neg_a ? -i_a : i_a;
         r_b      <= w_neg_b ? -i_b : i_b;
      end else if (r_busy) begin
         r_hi  <= w_nhi;
         r_lo  <= w_nlo;
         r_cnt <= r_cnt + 1'b1;
         if (o_done) begin
            r_busy <= 1'b0;
         end
      end
   end
endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// seq_alu : handshaked RV32I/M-style ALU; define SEQ_ALU_MDU_EN for M ops
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   seq_alu_if.slave bus
);
   localparam int              SW    = $clog2(XLEN);
   localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t          r_state, w_next;
   logic [XLEN-1:0] r_result;
   logic            r_zero, r_sign, r_ovf, r_carry, r_ill;

   logic [XLEN-1:0] w_a, w_b, w_res, w_sub, w_mdu_res;
   logic [XLEN:0]   w_add;
   logic [SW-1:0]   w_shamt;
   logic            w_carry, w_ovf, w_ill, w_iter, w_accept, w_mdu_done;

   assign w_a      = bus.op1;
   assign w_b      = bus.op2;
   assign w_shamt  = w_b[SW-1:0];
   assign w_add    = {1'b0, w_a} + {1'b0, w_b};
   assign w_sub    = w_a - w_b;
   assign w_accept = bus.in_valid && bus.in_ready;

   always_comb begin
      w_res   = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      w_ill   = 1'b0;
      w_iter  = 1'b0;
      if (!bus.op[4]) begin
         case (bus.op[3:0])
            C_OP_ADD: begin
               w_res   = w_add[XLEN-1:0];
               w_carry = w_add[XLEN];
               w_ovf   = (w_a[XLEN-1] == w_b[XLEN-1]) && (w_add[XLEN-1] != w_a[XLEN-1]);
            end
            C_OP_SUB: begin
               w_res   = w_sub;
               w_carry = w_a < w_b;
               w_ovf   = (w_a[XLEN-1] != w_b[XLEN-1]) && (w_sub[XLEN-1] != w_a[XLEN-1]);
            end
            C_OP_AND:  w_res = w_a & w_b;
            C_OP_OR:   w_res = w_a | w_b;
            C_OP_XOR:  w_res = w_a ^ w_b;
            C_OP_SLL:  w_res = w_a << w_shamt;
            C_OP_SRL:  w_res = w_a >> w_shamt;
            C_OP_SRA:  w_res = $signed(w_a) >>> w_shamt;
            C_OP_SLT:  w_res = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            C_OP_SLTU: w_res = {{(XLEN-1){1'b0}}, w_a < w_b};
            default:   w_ill = 1'b1;
         endcase
      end else begin
`ifdef SEQ_ALU_MDU_EN
         // Divide-by-zero and signed overflow resolve in one cycle
         if (bus.op[2] && (w_b == '0)) begin
            w_res = bus.op[1] ? w_a : '1;
         end else if (bus.op[2] && !bus.op[0] && (w_a == C_MIN) && (w_b == '1)) begin
            w_res = bus.op[1] ? '0 : w_a;
         end else begin
            w_iter = 1'b1;
         end
`else
         w_ill = 1'b1;
`endif
      end
   end

`ifdef SEQ_ALU_MDU_EN
   seq_alu_muldiv #(.XLEN(XLEN)) u_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (w_accept && w_iter),
      .i_f3     (bus.op[2:0]),
      .i_a      (w_a),
      .i_b      (w_b),
      .o_done   (w_mdu_done),
      .o_result (w_mdu_res)
   );
`else
   assign w_mdu_done = 1'b0;
   assign w_mdu_res  = '0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = w_iter ? ST_BUSY : ST_DONE;
         ST_BUSY: if (w_mdu_done) w_next = ST_DONE;
         ST_DONE: begin
            if (bus.out_ready) begin
               w_next = w_accept ? (w_iter ? ST_BUSY : ST_DONE) : ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_zero   <= 1'b0;
         r_sign   <= 1'b0;
         r_ovf    <= 1'b0;
         r_carry  <= 1'b0;
         r_ill    <= 1'b0;
      end else if (w_accept && !w_iter) begin
         r_result <= w_res;
         r_zero   <= (w_res == '0);
         r_sign   <= w_res[XLEN-1];
         r_ovf    <= w_ovf;
         r_carry  <= w_carry;
         r_ill    <= w_ill;
      end else if ((r_state == ST_BUSY) && w_mdu_done) begin
         r_result <= w_mdu_res;
         r_zero   <= (w_mdu_res == '0);
         r_sign   <= w_mdu_res[XLEN-1];
         r_ovf    <= 1'b0;
         r_carry  <= 1'b0;
         r_ill    <= 1'b0;
      end
   end

   assign bus.in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.result    = r_result;
   assign bus.zero      = r_zero;
   assign bus.sign      = r_sign;
   assign bus.overflow  = r_ovf;
   assign bus.carry     = r_carry;
   assign bus.illegal   = r_ill;
endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// tb_seq_alu : randomized scoreboard bench for seq_alu (honours SEQ_ALU_MDU_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_alu;
   localparam int XLEN = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   ready_mode = 0;   // 0: hold low, 1: hold high, 2: random

   seq_alu_if #(.XLEN(XLEN)) bus ();

   seq_alu #(.XLEN(XLEN)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  flags;   // {zero, sign, overflow, carry, illegal}
      int          lat;
      int          first;
   } exp_t;

   exp_t exp_q[$];

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        m;
      logic [63:0] pu;
      longint      sa, sb, t;
      logic        v, c, ill;
      logic [31:0] r;
      sa = $signed(a);
      sb = $signed(b);
      r = '0; v = 1'b0; c = 1'b0; ill = 1'b0;
      m.lat = 1;
      if (!op[4]) begin
         case (op[3:0])
            4'b0000: begin
               pu = {32'b0, a} + {32'b0, b};
               r = pu[31:0]; c = pu[32];
               t = sa + sb; v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'b1000: begin
               r = a - b; c = (a < b);
               t = sa - sb; v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'b0111: r = a & b;
            4'b0110: r = a | b;
            4'b0100: r = a ^ b;
            4'b0001: r = a << b[4:0];
            4'b0101: r = a >> b[4:0];
            4'b1101: begin t = sa >>> b[4:0]; r = t[31:0]; end
            4'b0010: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            default: ill = 1'b1;
         endcase
      end else begin
`ifdef SEQ_ALU_MDU_EN
         m.lat = XLEN + 1;
         case (op[2:0])
            3'd0: begin pu = {32'b0, a} * {32'b0, b}; r = pu[31:0]; end
            3'd1: begin t = sa * sb; r = t[63:32]; end
            3'd2: begin t = sa * longint'({32'b0, b}); r = t[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
            3'd4: if (b == 0) begin r = '1; m.lat = 1; end
                  else if (a == 32'h8000_0000 && b == '1) begin r = a; m.lat = 1; end
                  else begin t = sa / sb; r = t[31:0]; end
            3'd5: if (b == 0) begin r = '1; m.lat = 1; end
                  else r = a / b;
            3'd6: if (b == 0) begin r = a; m.lat = 1; end
                  else if (a == 32'h8000_0000 && b == '1) begin r = '0; m.lat = 1; end
                  else begin t = sa % sb; r = t[31:0]; end
            default: if (b == 0) begin r = a; m.lat = 1; end
                     else r = a % b;
         endcase
`else
         ill = 1'b1;
`endif
      end
      m.res   = r;
      m.flags = {r == 0, r[31], v, c, ill};
      m.first = 0;
      return m;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         bus.out_ready = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
      end
   end

   // Monitor: compares each consumed result against the scoreboard head
   initial begin
      logic seen;
      int   first_cyc;
      exp_t e;
      seen = 1'b0;
      first_cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 1'b0;
         end else if (bus.out_valid) begin
            if (!seen) begin
               seen = 1'b1;
               first_cyc = cyc;
            end
            if (bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_result", 64'(bus.result), 64'hdead_0000_0000_0000);
               end else begin
                  e = exp_q.pop_front();
                  check("result", 64'(bus.result), 64'(e.res));
                  check("flags", 64'({bus.zero, bus.sign, bus.overflow, bus.carry, bus.illegal}),
                        64'(e.flags));
                  check("latency", 64'(first_cyc), 64'(e.first));
               end
               seen = 1'b0;
            end
         end
      end
   end

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      bit   done;
      exp_t e;
      done = 1'b0;
      bus.in_valid = 1'b1;
      bus.op  = op;
      bus.op1 = a;
      bus.op2 = b;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            e = model(op, a, b);
            e.first = cyc + e.lat;
            exp_q.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.op1 = $urandom;
      bus.op2 = $urandom;
      check("accept", 64'(done), 64'd1);
   endtask

   task automatic drain();
      for (int k = 0; k < 3000; k++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'($urandom_range(0, 16));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      logic [4:0]  base_ops [10];
      logic [4:0]  bad_ops  [6];
      logic [4:0]  op;
      logic [31:0] res0;
      logic [4:0]  flg0;
      logic        stable, rdy_seen, late;
      int          c0, k;
      base_ops = '{5'b00000, 5'b01000, 5'b00111, 5'b00110, 5'b00100,
                   5'b00001, 5'b00101, 5'b01101, 5'b00010, 5'b00011};
      bad_ops  = '{5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01110, 5'b01111};
      bus.in_valid = 1'b0;
      bus.op  = '0;
      bus.op1 = '0;
      bus.op2 = '0;

      #12;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_result", 64'(bus.result), 64'd0);
      check("rst_flags", 64'({bus.zero, bus.sign, bus.overflow, bus.carry, bus.illegal}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      ready_mode = 2;

      issue(5'b00000, 32'hFFFF_FFFF, 32'h0000_0001);
      issue(5'b01000, 32'h8000_0000, 32'h0000_0001);
      issue(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(5'b10101, 32'd7, 32'd0);
      issue(5'b10111, 32'd7, 32'd0);
      issue(5'b10000, 32'd1234, 32'd5678);
      issue(5'b01010, 32'd9, 32'd3);
      issue(5'b01101, 32'h8000_00F0, 32'h0000_0024);

      for (int n = 0; n < 150; n++) begin
         k = $urandom_range(0, 13);
         if (k < 10)       op = base_ops[k];
         else if (k < 12)  op = {2'b10, 3'($urandom_range(0, 7))};
         else if (k == 12) op = bad_ops[$urandom_range(0, 5)];
         else              op = 5'($urandom);
         issue(op, rand_operand(), rand_operand());
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      // Stall on an AND result, then release with a same-cycle accept
      ready_mode = 1;
      drain();
      ready_mode = 0;
      @(posedge clk); #1;
      issue(5'b00111, 32'hF0F0_1234, 32'h0FF0_FF00);
      @(negedge clk);
      res0 = bus.result;
      flg0 = {bus.zero, bus.sign, bus.overflow, bus.carry, bus.illegal};
      stable = bus.out_valid;
      rdy_seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         stable &= bus.out_valid && (bus.result == res0) &&
                   ({bus.zero, bus.sign, bus.overflow, bus.carry, bus.illegal} == flg0);
         rdy_seen |= bus.in_ready;
      end
      check("stall_stable", 64'(stable), 64'd1);
      check("stall_in_ready_low", 64'(rdy_seen), 64'd0);
      @(posedge clk); #1;
      ready_mode = 1;
      c0 = cyc;
      issue(5'b00100, 32'h1234_5678, 32'hFFFF_0000);
      check("same_cycle_accept", 64'(cyc - c0), 64'd1);

      // Reset in the middle of a DIVU
      drain();
      ready_mode = 0;
      @(posedge clk); #1;
      issue(5'b10101, 32'($urandom), 32'd3);
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 64'(bus.out_valid), 64'd0);
      check("abort_result", 64'(bus.result), 64'd0);
      check("abort_flags", 64'({bus.zero, bus.sign, bus.overflow, bus.carry, bus.illegal}), 64'd0);
      exp_q.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      ready_mode = 1;
      @(negedge clk);
      check("ready_after_abort", 64'(bus.in_ready), 64'd1);
      late = 1'b0;
      repeat (XLEN + 5) begin
         @(negedge clk);
         late |= bus.out_valid;
      end
      check("no_late_result", 64'(late), 64'd0);

      @(posedge clk); #1;
      issue(5'b00000, 32'h7FFF_FFFF, 32'h0000_0001);
      issue(5'b10000, 32'hFFFF_FFFD, 32'h0000_0007);
      drain();
      repeat (3) @(posedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end
endmodule

`default_nettype wire
